// File: rtl/dvi_scanout.sv
// Video scan-out: programmable H/V timing, sequential framebuffer reads, 1/8/24-bit to RGB expansion.
// Latency: counter state to video_*/pixel_rgb/frame_start is READ_LATENCY+1 cycles.
// Backpressure: none; free-running at pixel rate. enable=0 stops only at the end of a frame.
//
// Ports: clk_i/rst_i (async active-high), enable_i run request, fg/bg_color_i for 1-bit pixels,
//        fb_addr_o/fb_data_i framebuffer read port, pixel_rgb_o/video_de_o/video_h_o/video_v_o
//        to the DVI transmitter, vblank_o (undelayed) and frame_start_o for the CPU side.
module dvi_scanout #(
    parameter int H_ACTIVE      = 1024,
    parameter int H_FP          = 24,
    parameter int H_SYNC        = 136,
    parameter int H_BP          = 160,
    parameter int V_ACTIVE      = 768,
    parameter int V_FP          = 3,
    parameter int V_SYNC        = 6,
    parameter int V_BP          = 29,
    parameter bit SYNC_POLARITY = 1'b0,
    parameter int PIXEL_BITS    = 1,
    parameter int READ_LATENCY  = 1,
    parameter int ADDR_W        = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [23:0]           fg_color_i,
    input  logic [23:0]           bg_color_i,
    output logic [ADDR_W-1:0]     fb_addr_o,
    input  logic [PIXEL_BITS-1:0] fb_data_i,
    output logic [23:0]           pixel_rgb_o,
    output logic                  video_de_o,
    output logic                  video_h_o,
    output logic                  video_v_o,
    output logic                  vblank_o,
    output logic                  frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit of headroom so sync-end bounds equal to the total still fit.
    localparam int H_W = $clog2(H_TOTAL + 1);
    localparam int V_W = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
    localparam logic [H_W-1:0] HS_BEG     = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] VS_BEG     = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);

    if (PIXEL_BITS != 1 && PIXEL_BITS != 8 && PIXEL_BITS != 24) begin : g_bad_pixel_bits
        $error("dvi_scanout: PIXEL_BITS must be 1, 8 or 24");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("dvi_scanout: READ_LATENCY must be 1..4");
    end
    if ((longint'(1) << ADDR_W) < longint'(H_ACTIVE) * longint'(V_ACTIVE)) begin : g_bad_addr_w
        $error("dvi_scanout: ADDR_W too small for the active frame");
    end

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic first;
    } ctl_t;

    state_t            state_q, state_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic run, h_end, frame_end, last_act;
    ctl_t ctl0;

    assign run       = (state_q == ST_RUN);
    assign h_end     = (h_q == H_LAST);
    assign frame_end = h_end && (v_q == V_LAST);
    assign last_act  = (h_q == H_ACT_LAST) && (v_q == V_ACT_LAST);

    // Stage-0 controls; all forced inactive while stopped.
    assign ctl0.act   = run && (h_q < H_ACT) && (v_q < V_ACT);
    assign ctl0.hs    = run && (h_q >= HS_BEG) && (h_q < HS_END);
    assign ctl0.vs    = run && (v_q >= VS_BEG) && (v_q < VS_END);
    assign ctl0.first = run && (h_q == '0) && (v_q == '0);

    assign vblank_o  = !run || !(v_q < V_ACT);
    assign fb_addr_o = addr_q;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_STOP: begin
                h_d    = '0;
                v_d    = '0;
                addr_d = '0;
                if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (h_end) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
                end else begin
                    h_d = h_q + H_W'(1);
                end
                // Incremental address: no multiply, wraps to 0 after the last visible pixel.
                if (ctl0.act) addr_d = last_act ? '0 : addr_q + ADDR_W'(1);
                // Stopping only at the frame boundary means a frame is never truncated.
                if (frame_end && !enable_i) state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_STOP;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
        end
    end

    // Controls delayed to line up with fb_data; the last tap is aligned with the returning word.
    ctl_t dly_q [READ_LATENCY];
    ctl_t tap;
    assign tap = dly_q[READ_LATENCY-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LATENCY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= ctl0;
            for (int i = 1; i < READ_LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    logic [23:0] pix_exp;
    if (PIXEL_BITS == 1) begin : g_mono
        assign pix_exp = fb_data_i[0] ? fg_color_i : bg_color_i;
    end else if (PIXEL_BITS == 8) begin : g_rgb332
        // Replicate the high bits so full-scale codes reach 0xFF.
        assign pix_exp = {fb_data_i[7:5], fb_data_i[7:5], fb_data_i[7:6],
                          fb_data_i[4:2], fb_data_i[4:2], fb_data_i[4:3],
                          {4{fb_data_i[1:0]}}};
    end else if (PIXEL_BITS == 24) begin : g_rgb888
        assign pix_exp = fb_data_i[23:0];
    end else begin : g_none
        assign pix_exp = '0;
    end

    logic [23:0] rgb_q;
    logic        de_q, hsync_q, vsync_q, fs_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POLARITY;
            vsync_q <= ~SYNC_POLARITY;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= tap.act ? pix_exp : '0;
            de_q    <= tap.act;
            hsync_q <= tap.hs ? SYNC_POLARITY : ~SYNC_POLARITY;
            vsync_q <= tap.vs ? SYNC_POLARITY : ~SYNC_POLARITY;
            fs_q    <= tap.first;
        end
    end

    assign pixel_rgb_o   = rgb_q;
    assign video_de_o    = de_q;
    assign video_h_o     = hsync_q;
    assign video_v_o     = vsync_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_dvi_scanout.sv
// Bench for dvi_scanout on a reduced 16x8 raster (8x4 visible, 128 cycles per frame).
// Two instances: RGB332 with read latency 2 and active-low syncs; 1-bit mono with latency 1
// and active-high syncs. Expected pixels are queued at stimulus time and popped on DE.
module tb_dvi_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = HA * VA;
    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000080;

    typedef struct {
        logic [23:0] rgb;
        logic        first;
    } exp_t;

    logic clk, rst, enable;
    logic [23:0] fg, bg;

    logic [4:0]  addr0, addr1;
    logic [7:0]  fbd0;
    logic        fbd1;
    logic [23:0] rgb0, rgb1;
    logic        de0, vh0, vv0, vb0, fs0;
    logic        de1, vh1, vv1, vb1, fs1;

    dvi_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .SYNC_POLARITY(1'b0), .PIXEL_BITS(8), .READ_LATENCY(2), .ADDR_W(5)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fg_color_i(fg), .bg_color_i(bg),
        .fb_addr_o(addr0), .fb_data_i(fbd0), .pixel_rgb_o(rgb0), .video_de_o(de0),
        .video_h_o(vh0), .video_v_o(vv0), .vblank_o(vb0), .frame_start_o(fs0));

    dvi_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .SYNC_POLARITY(1'b1), .PIXEL_BITS(1), .READ_LATENCY(1), .ADDR_W(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fg_color_i(fg), .bg_color_i(bg),
        .fb_addr_o(addr1), .fb_data_i(fbd1), .pixel_rgb_o(rgb1), .video_de_o(de1),
        .video_h_o(vh1), .video_v_o(vv1), .vblank_o(vb1), .frame_start_o(fs1));

    // Framebuffer models with 2-cycle and 1-cycle read latency.
    logic [7:0] mem8 [NPIX];
    logic       mem1 [NPIX];
    logic [7:0] rd0_a, rd0_b;
    logic       rd1;
    always @(posedge clk) begin
        rd0_a <= mem8[addr0];
        rd0_b <= rd0_a;
        rd1   <= mem1[addr1];
    end
    assign fbd0 = rd0_b;
    assign fbd1 = rd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    int popped0 = 0;
    int run_id = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_dut0"}, {30'd0, de0, vh0, vv0, fs0, vb0, addr0, rgb0},
            {30'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 24'd0});
        chk({nm, "_dut1"}, {30'd0, de1, vh1, vv1, fs1, vb1, addr1, rgb1},
            {30'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 24'd0});
    endtask

    // RGB332 expansion: 3-bit r -> r*36 + r/2 (i.e. r<<5 | r<<2 | r>>1), 2-bit b -> b*0x55.
    function automatic logic [23:0] exp332(input logic [7:0] d);
        logic [7:0] r, g, b;
        r = {5'd0, d[7:5]};
        g = {5'd0, d[4:2]};
        b = {6'd0, d[1:0]};
        return {(r << 5) | (r << 2) | (r >> 1), (g << 5) | (g << 2) | (g >> 1), b * 8'h55};
    endfunction

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int p = 0; p < NPIX; p++) begin
                q0.push_back('{exp332(mem8[p]), p == 0});
                q1.push_back('{(p < 2 * HA) ? FG : BG, p == 0});
            end
        end
    endtask

    // Monitor for the RGB332 instance: pixels, frame_start, sync geometry, address hold.
    int cyc = 0;
    int hlow = 0, vlow = 0, t_defall = 0, t_fs = 0, fs_run = -1;
    logic prev_h = 1'b1, prev_v = 1'b1, prev_de = 1'b0, de_line = 1'b0, prev_vb = 1'b1;
    logic [4:0] prev_addr = '0;
    exp_t e0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (de0) begin
            if (q0.size() == 0) chk("dut0_extra_pixel", 64'(q0.size()), 64'd1);
            else begin
                e0 = q0.pop_front();
                chk("dut0_pixel", 64'(rgb0), 64'(e0.rgb));
                chk("dut0_frame_start", 64'(fs0), 64'(e0.first));
                popped0++;
            end
        end else begin
            chk("dut0_blank_out", {39'd0, fs0, rgb0}, 64'd0);
        end
        if (fs0) begin
            if (fs_run == run_id) chk("dut0_frame_period", 64'(cyc - t_fs), 64'(HT * VT));
            t_fs = cyc;
            fs_run = run_id;
        end
        if (prev_de && !de0) begin
            t_defall = cyc;
            de_line = 1'b1;
        end
        if (!vh0 && prev_h && de_line) begin
            chk("dut0_hsync_front_porch", 64'(cyc - t_defall), 64'(HF));
            de_line = 1'b0;
        end
        if (!vh0) hlow++;
        if (vh0 && !prev_h) begin
            chk("dut0_hsync_width", 64'(hlow), 64'(HS));
            hlow = 0;
        end
        if (!vv0) vlow++;
        if (vv0 && !prev_v) begin
            chk("dut0_vsync_width", 64'(vlow), 64'(VS * HT));
            vlow = 0;
        end
        if (vb0 && prev_vb) chk("dut0_addr_hold_vblank", 64'(addr0), 64'(prev_addr));
        prev_h = vh0;
        prev_v = vv0;
        prev_de = de0;
        prev_vb = vb0;
        prev_addr = addr0;
    end

    // Monitor for the mono instance.
    exp_t e1;
    initial forever begin
        @(negedge clk);
        if (de1) begin
            if (q1.size() == 0) chk("dut1_extra_pixel", 64'(q1.size()), 64'd1);
            else begin
                e1 = q1.pop_front();
                chk("dut1_pixel", 64'(rgb1), 64'(e1.rgb));
                chk("dut1_frame_start", 64'(fs1), 64'(e1.first));
            end
        end else begin
            chk("dut1_blank_out", {39'd0, fs1, rgb1}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, guard;
        rst = 1'b1;
        enable = 1'b0;
        fg = FG;
        bg = BG;
        for (int a = 0; a < NPIX; a++) begin
            mem8[a] = 8'((a * 37 + 227) & 255);   // address 0 holds 0xE3
            mem1[a] = (a < 2 * HA);                // rows 0-1 lit, rows 2-3 dark
        end
        mem8[5] = 8'h00;
        mem8[9] = 8'hFF;

        repeat (3) @(negedge clk);
        chk_idle("reset_values");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk_idle("stopped_idle");
        end

        // Two frames; enable drops mid-way through the second, which must still complete.
        run_id = 1;
        push_frames(2);
        enable = 1'b1;
        repeat (HT * VT + HT * 4) @(negedge clk);
        enable = 1'b0;
        repeat (HT * VT / 2 + 20) @(negedge clk);
        chk("run1_dut0_drained", 64'(q0.size()), 64'd0);
        chk("run1_dut1_drained", 64'(q1.size()), 64'd0);
        chk_idle("after_stop");

        // Async reset part-way through line 1.
        run_id = 2;
        push_frames(1);
        base0 = popped0;
        @(negedge clk);
        enable = 1'b1;
        guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while ((popped0 - base0) < 11 && guard < 400);
        chk("run2_pixels_before_reset", 64'(popped0 - base0), 64'd11);
        rst = 1'b1;
        #1;
        chk_idle("async_reset");
        chk("run2_dut0_left", 64'(q0.size()), 64'(NPIX - 11));
        chk("run2_dut1_left", 64'(q1.size()), 64'(NPIX - 12));
        q0.delete();
        q1.delete();

        // Restart from (0,0) after reset with enable already high; run exactly one frame.
        run_id = 3;
        push_frames(1);
        repeat (3) @(negedge clk);
        chk_idle("reset_held_enable_high");
        rst = 1'b0;
        repeat (HT * VT / 2) @(negedge clk);
        enable = 1'b0;
        repeat (HT * VT / 2 + 20) @(negedge clk);
        chk("run3_dut0_drained", 64'(q0.size()), 64'd0);
        chk("run3_dut1_drained", 64'(q1.size()), 64'd0);
        chk_idle("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
